// File: rtl/l3_weight_fetch_if.sv
// Bundle between the layer-3 weight fetch sequencer, its ROM bank and the conv engine.
// master: the sequencer side. slave: the ROM/engine/control side.
interface l3_weight_fetch_if #(
   parameter int unsigned ADDR_W = 6
);

   // Control
   logic                start;
   logic                busy;
   logic                done;

   // ROM side
   logic [ADDR_W-1:0]   weg_addr;
   logic [4607:0]       conv_weight_in;
   logic signed [15:0]  conv_bias_in;

   // Conv engine side
   logic [4607:0]       kern_weight;
   logic signed [15:0]  kern_bias;
   logic [ADDR_W-1:0]   kern_idx;
   logic                kern_valid;
   logic                kern_ready;
   logic                kern_last;

   modport master (
      input  start,
      input  conv_weight_in,
      input  conv_bias_in,
      input  kern_ready,
      output busy,
      output done,
      output weg_addr,
      output kern_weight,
      output kern_bias,
      output kern_idx,
      output kern_valid,
      output kern_last
   );

   modport slave (
      output start,
      output conv_weight_in,
      output conv_bias_in,
      output kern_ready,
      input  busy,
      input  done,
      input  weg_addr,
      input  kern_weight,
      input  kern_bias,
      input  kern_idx,
      input  kern_valid,
      input  kern_last
   );

endinterface

// File: rtl/l3_weight_fetch.sv
// Layer-3 weight/bias fetch sequencer. Sweeps the ROM address 0..NUM_KERNELS-1, waits out the
// ROM read latency, latches one output channel's kernels and bias and offers them downstream
// under valid/ready, one channel per transfer.
module l3_weight_fetch #(
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned NUM_KERNELS = 64,
   parameter int unsigned ROM_LAT     = 1
) (
   input logic               clk,
   input logic               rst,
   l3_weight_fetch_if.master bus_io
);

   localparam int unsigned CntW = (ROM_LAT > 1) ? $clog2(ROM_LAT + 1) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StHold = 2'd2;
   localparam logic [1:0] StFin  = 2'd3;

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_KERNELS - 1);
   localparam logic [CntW-1:0]   CapCnt  = CntW'(ROM_LAT);

   logic [1:0]         state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]  weg_addr_q, weg_addr_d;
   logic [4607:0]      kern_weight_q, kern_weight_d;
   logic [15:0]        kern_bias_q, kern_bias_d;
   logic [ADDR_W-1:0]  kern_idx_q, kern_idx_d;
   logic               kern_valid_q, kern_valid_d;
   logic               done_q, done_d;
   logic               handshake;

   assign handshake = kern_valid_q & bus_io.kern_ready;

   // Next-state: FSM, address sequencing, latency counter and capture of the ROM output.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      weg_addr_d    = weg_addr_q;
      kern_weight_d = kern_weight_q;
      kern_bias_d   = kern_bias_q;
      kern_idx_d    = kern_idx_q;
      kern_valid_d  = kern_valid_q;
      done_d        = 1'b0;

      case (state_q)
         StIdle: begin
            weg_addr_d = '0;
            if (bus_io.start) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end

         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            // ROM output for weg_addr is valid once the counter reaches the read latency.
            if (cnt_q == CapCnt) begin
               kern_weight_d = bus_io.conv_weight_in;
               kern_bias_d   = bus_io.conv_bias_in;
               kern_idx_d    = weg_addr_q;
               kern_valid_d  = 1'b1;
               state_d       = StHold;
            end
         end

         StHold: begin
            if (handshake) begin
               kern_valid_d = 1'b0;
               // Last channel: no increment, so the address never passes NUM_KERNELS-1.
               if (kern_idx_q == LastIdx) begin
                  state_d = StFin;
               end else begin
                  weg_addr_d = weg_addr_q + ADDR_W'(1);
                  cnt_d      = '0;
                  state_d    = StWait;
               end
            end
         end

         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-high reset; reset abandons any sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         weg_addr_q    <= '0;
         kern_weight_q <= '0;
         kern_bias_q   <= '0;
         kern_idx_q    <= '0;
         kern_valid_q  <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         weg_addr_q    <= weg_addr_d;
         kern_weight_q <= kern_weight_d;
         kern_bias_q   <= kern_bias_d;
         kern_idx_q    <= kern_idx_d;
         kern_valid_q  <= kern_valid_d;
         done_q        <= done_d;
      end
   end

   assign bus_io.weg_addr    = weg_addr_q;
   assign bus_io.kern_weight = kern_weight_q;
   assign bus_io.kern_bias   = kern_bias_q;
   assign bus_io.kern_idx    = kern_idx_q;
   assign bus_io.kern_valid  = kern_valid_q;
   assign bus_io.kern_last   = kern_valid_q & (kern_idx_q == LastIdx);
   assign bus_io.busy        = (state_q != StIdle);
   assign bus_io.done        = done_q;

endmodule
